// File: rtl/sia_pkg.sv
// rtl/sia_pkg.sv - shared SIA state encodings, txcmod bit indices and default widths
package sia_pkg;

    localparam int SIA_SHIFT_W    = 12;
    localparam int SIA_BAUD_W     = 32;
    localparam int SIA_DEPTH_BITS = 2;
    localparam int SIA_BITS_W     = 5;

    localparam int TXC_LVL = 0;
    localparam int TXC_INV = 1;
    localparam int TXC_EN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_BREAK = 2'd2
    } sia_state_e;

endpackage

// File: rtl/sia_fifo.sv
// rtl/sia_fifo.sv - synchronous word FIFO with fill level, flush and sticky dropped-write flag
module sia_fifo
    import sia_pkg::*;
#(
    parameter int WIDTH      = SIA_SHIFT_W,
    parameter int DEPTH_BITS = SIA_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_BITS:0]   level,
    output logic                  not_full,
    output logic                  empty,
    output logic                  ovf
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Fullness is judged on the registered count, so a pop on the same edge never rescues a write.
    assign full  = (count == (DEPTH_BITS+1)'(DEPTH));
    assign push  = wr_en & ~full & ~flush;
    assign pop   = rd_en & (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + DEPTH_BITS'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + DEPTH_BITS'(1);
                end
                count <= count + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
            end
            if (wr_en && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign level    = count;
    assign not_full = ~full;
    assign empty    = (count == '0);

endmodule

// File: rtl/sia_txq_fc.sv
// rtl/sia_txq_fc.sv - SIA transmit queue: FIFO, CTS flow control, break and bit-clocked shifter
module sia_txq_fc
    import sia_pkg::*;
#(
    parameter int SHIFT_REG_WIDTH = SIA_SHIFT_W,
    parameter int BAUD_RATE_WIDTH = SIA_BAUD_W,
    parameter int DEPTH_BITS      = SIA_DEPTH_BITS,
    parameter int BITS_WIDTH      = SIA_BITS_W
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [SHIFT_REG_WIDTH-1:0] dat_i,
    input  logic                       we_i,
    input  logic                       flush_i,
    input  logic [BITS_WIDTH-1:0]      bits_i,
    input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
    input  logic [2:0]                 txcmod_i,
    input  logic                       cts_en_i,
    input  logic                       cts_i,
    input  logic                       brk_i,
    input  logic                       ovf_clr_i,
    output logic                       txd_o,
    output logic                       txc_o,
    output logic                       not_full_o,
    output logic                       empty_o,
    output logic                       idle_o,
    output logic [DEPTH_BITS:0]        level_o,
    output logic                       ovf_o
);

    logic                       cts_meta;
    logic                       cts_sync;
    logic                       start_ok;
    logic [SHIFT_REG_WIDTH-1:0] head;
    logic                       empty;
    logic                       pop;

    sia_state_e                 state;
    logic [SHIFT_REG_WIDTH-1:0] shreg;
    logic [BITS_WIDTH-1:0]      bitcnt;
    logic [BAUD_RATE_WIDTH-1:0] baudcnt;
    logic [BITS_WIDTH-1:0]      frame_bits;
    logic                       frame_end;
    logic                       decide;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
        end else begin
            cts_meta <= cts_i;
            cts_sync <= cts_meta;
        end
    end

    assign start_ok = ~cts_en_i | cts_sync;

    sia_fifo #(
        .WIDTH      (SHIFT_REG_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .wr_en    (we_i),
        .wr_data  (dat_i),
        .rd_en    (pop),
        .flush    (flush_i),
        .ovf_clr  (ovf_clr_i),
        .rd_data  (head),
        .level    (level_o),
        .not_full (not_full_o),
        .empty    (empty),
        .ovf      (ovf_o)
    );

    assign frame_bits = (32'(bits_i) > 32'(SHIFT_REG_WIDTH)) ? BITS_WIDTH'(SHIFT_REG_WIDTH) : bits_i;

    // The last clock of the last bit doubles as an IDLE decision so frames run back-to-back.
    assign frame_end = (state == ST_SHIFT) && (baudcnt == '0) && (bitcnt <= BITS_WIDTH'(1));
    assign decide    = (state == ST_IDLE) || frame_end;
    assign pop       = decide && !brk_i && !empty && start_ok;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= ST_IDLE;
            shreg   <= '1;
            bitcnt  <= '0;
            baudcnt <= '0;
        end else if (decide) begin
            if (brk_i) begin
                state <= ST_BREAK;
            end else if (pop && (frame_bits != '0)) begin
                state   <= ST_SHIFT;
                shreg   <= head;
                bitcnt  <= frame_bits;
                baudcnt <= baud_i;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (baudcnt != '0) begin
                        baudcnt <= baudcnt - BAUD_RATE_WIDTH'(1);
                    end else begin
                        baudcnt <= baud_i;
                        shreg   <= {1'b1, shreg[SHIFT_REG_WIDTH-1:1]};
                        bitcnt  <= bitcnt - BITS_WIDTH'(1);
                    end
                end
                ST_BREAK: begin
                    if (!brk_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign txd_o   = (state == ST_SHIFT) ? shreg[0] : (state != ST_BREAK);
    assign empty_o = empty;
    assign idle_o  = empty && (state == ST_IDLE);

    always_comb begin
        txc_o = txcmod_i[TXC_INV];
        if (reset_i) begin
            if (!txcmod_i[TXC_EN]) begin
                txc_o = txcmod_i[TXC_LVL];
            end else if (state == ST_SHIFT) begin
                txc_o = (baudcnt <= (baud_i >> 1)) ^ txcmod_i[TXC_INV];
            end
        end
    end

endmodule

// File: tb/tb_sia_txq_fc.sv
// tb/tb_sia_txq_fc.sv - self-checking bench for sia_txq_fc against a queue/bit-index line model
module tb_sia_txq_fc;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [11:0] dat_i = '0;
    logic        we_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  bits_i = 5'd10;
    logic [31:0] baud_i = 32'd49;
    logic [2:0]  txcmod_i = 3'b000;
    logic        cts_en_i = 1'b0;
    logic        cts_i = 1'b0;
    logic        brk_i = 1'b0;
    logic        ovf_clr_i = 1'b0;
    logic        txd_o, txc_o, not_full_o, empty_o, idle_o, ovf_o;
    logic [2:0]  level_o;

    sia_txq_fc dut (
        .clk_i(clk), .reset_i(reset_i), .dat_i(dat_i), .we_i(we_i), .flush_i(flush_i),
        .bits_i(bits_i), .baud_i(baud_i), .txcmod_i(txcmod_i), .cts_en_i(cts_en_i),
        .cts_i(cts_i), .brk_i(brk_i), .ovf_clr_i(ovf_clr_i), .txd_o(txd_o), .txc_o(txc_o),
        .not_full_o(not_full_o), .empty_o(empty_o), .idle_o(idle_o), .level_o(level_o),
        .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: queued words, and the frame in flight as (word, bit index, clocks into bit).
    logic [11:0] mq[$];
    bit          m_ovf, m_busy, m_brk;
    logic [11:0] m_word;
    int          m_nbits, m_bit;
    longint      m_t, m_baud;
    bit [1:0]    m_cts;

    always @(posedge clk) begin
        if (!reset_i) begin
            mq.delete();
            m_ovf = 0; m_busy = 0; m_brk = 0; m_cts = 2'b00;
            m_bit = 0; m_t = 0; m_nbits = 0; m_baud = 0; m_word = '1;
        end else begin
            bit decide, sok, full, emp;
            int nb;
            logic [11:0] w;
            decide = 0;
            sok  = !cts_en_i || m_cts[1];
            full = (mq.size() == 4);
            emp  = (mq.size() == 0);
            if (m_busy) begin
                if (m_t == m_baud) begin
                    if (m_bit == m_nbits - 1) begin
                        m_busy = 0;
                        decide = 1;
                    end else begin
                        m_bit++;
                        m_t = 0;
                        m_baud = longint'(baud_i);
                    end
                end else begin
                    m_t++;
                end
            end else if (m_brk) begin
                if (!brk_i) m_brk = 0;
            end else begin
                decide = 1;
            end
            if (decide) begin
                if (brk_i) begin
                    m_brk = 1;
                end else if (!emp && sok) begin
                    w  = mq.pop_front();
                    nb = (int'(bits_i) > 12) ? 12 : int'(bits_i);
                    if (nb != 0) begin
                        m_busy = 1; m_word = w; m_nbits = nb; m_bit = 0; m_t = 0;
                        m_baud = longint'(baud_i);
                    end
                end
            end
            if (flush_i) mq.delete();
            else if (we_i && !full) mq.push_back(dat_i);
            if (we_i && full) m_ovf = 1;
            else if (ovf_clr_i) m_ovf = 0;
            m_cts = {m_cts[0], cts_i};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_txd, e_txc;
            e_txd = m_busy ? m_word[m_bit] : !m_brk;
            if (!reset_i) e_txc = txcmod_i[1];
            else if (!txcmod_i[2]) e_txc = txcmod_i[0];
            else if (m_busy) e_txc = ((m_baud - m_t) <= longint'(baud_i >> 1)) ^ txcmod_i[1];
            else e_txc = txcmod_i[1];
            chk("txd", 32'(txd_o), 32'(e_txd));
            chk("txc", 32'(txc_o), 32'(e_txc));
            chk("level", 32'(level_o), 32'(mq.size()));
            chk("empty", 32'(empty_o), 32'(mq.size() == 0));
            chk("not_full", 32'(not_full_o), 32'(mq.size() < 4));
            chk("idle", 32'(idle_o), 32'(mq.size() == 0 && !m_busy && !m_brk));
            chk("ovf", 32'(ovf_o), 32'(m_ovf));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [11:0] w);
        dat_i = w;
        we_i  = 1'b1;
        step(1);
        we_i  = 1'b0;
    endtask

    localparam logic [11:0] W1 = 12'b111_11101101_0;

    initial begin
        int e1[10];
        e1 = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 1};
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("rst_txd", 32'(txd_o), 32'd1);
        chk("rst_txc", 32'(txc_o), 32'd0);
        chk("rst_not_full", 32'(not_full_o), 32'd1);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        reset_i = 1'b1;
        step(2);

        // 8N1 frame, 50 clocks per bit
        push(W1);
        step(26);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("f1_bit%0d", k), 32'(txd_o), 32'(e1[k]));
            if (k < 9) step(50);
        end
        step(24);
        chk("f1_idle_late", 32'(idle_o), 32'd0);
        step(1);
        chk("f1_idle_rise", 32'(idle_o), 32'd1);

        // Fill and overflow with CTS held off, then drain back-to-back
        cts_en_i = 1'b1;
        for (int i = 0; i < 5; i++) push(W1 ^ 12'(i << 3));
        chk("fill_level", 32'(level_o), 32'd4);
        chk("fill_not_full", 32'(not_full_o), 32'd0);
        chk("fill_ovf", 32'(ovf_o), 32'd1);
        cts_i = 1'b1;
        step(2002);
        chk("drain_busy", 32'(idle_o), 32'd0);
        step(1);
        chk("drain_idle", 32'(idle_o), 32'd1);
        chk("drain_ovf_sticky", 32'(ovf_o), 32'd1);
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        chk("ovf_clr", 32'(ovf_o), 32'd0);

        // CTS drop mid-frame
        baud_i = 32'd9;
        push(W1);
        push(12'b111_01010101_0);
        step(20);
        cts_i = 1'b0;
        step(120);
        chk("cts_hold_level", 32'(level_o), 32'd1);
        chk("cts_hold_txd", 32'(txd_o), 32'd1);
        cts_i = 1'b1;
        step(2);
        chk("cts_sync_wait", 32'(txd_o), 32'd1);
        step(1);
        chk("cts_start", 32'(txd_o), 32'd0);
        step(110);
        cts_en_i = 1'b0;

        // Break while idle, then break raised mid-frame
        brk_i = 1'b1;
        step(1);
        chk("brk_idle_txd", 32'(txd_o), 32'd0);
        brk_i = 1'b0;
        step(1);
        chk("brk_rel_txd", 32'(txd_o), 32'd1);
        push(W1);
        step(30);
        brk_i = 1'b1;
        push(12'b111_00110011_0);
        step(75);
        chk("brk_after_frame", 32'(txd_o), 32'd0);
        chk("brk_level", 32'(level_o), 32'd1);
        brk_i = 1'b0;
        step(1);
        chk("brk_end_mark", 32'(txd_o), 32'd1);
        step(1);
        chk("brk_resume", 32'(txd_o), 32'd0);
        step(110);

        // Bit clock modes at baud 9
        txcmod_i = 3'b100;
        push(W1);
        step(1);
        chk("txc100_low", 32'(txc_o), 32'd0);
        step(5);
        chk("txc100_high", 32'(txc_o), 32'd1);
        step(100);
        txcmod_i = 3'b110;
        push(W1);
        step(1);
        chk("txc110_high", 32'(txc_o), 32'd1);
        step(5);
        chk("txc110_low", 32'(txc_o), 32'd0);
        step(100);
        txcmod_i = 3'b001;
        push(W1);
        step(3);
        chk("txc001_a", 32'(txc_o), 32'd1);
        step(50);
        chk("txc001_b", 32'(txc_o), 32'd1);
        step(60);
        txcmod_i = 3'b000;

        // bits_i above the register width clamps to 12 bits
        bits_i = 5'd14;
        push(12'b0111_1111_1110);
        step(106);
        chk("clamp_bit10", 32'(txd_o), 32'd1);
        step(10);
        chk("clamp_bit11", 32'(txd_o), 32'd0);
        step(4);
        chk("clamp_busy", 32'(idle_o), 32'd0);
        step(1);
        chk("clamp_idle", 32'(idle_o), 32'd1);

        // bits_i=0 discards the word
        bits_i = 5'd0;
        push(12'h000);
        step(1);
        chk("zero_level", 32'(level_o), 32'd0);
        chk("zero_txd", 32'(txd_o), 32'd1);
        step(3);
        chk("zero_txd_later", 32'(txd_o), 32'd1);
        bits_i = 5'd10;

        // Reset mid-frame
        push(W1);
        push(W1);
        step(30);
        reset_i = 1'b0;
        #1;
        chk("rstmid_txd", 32'(txd_o), 32'd1);
        chk("rstmid_level", 32'(level_o), 32'd0);
        step(2);
        reset_i = 1'b1;
        step(2);

        // Flush mid-frame: queue emptied, current frame completes
        push(W1);
        push(12'b111_00001111_0);
        push(12'b111_11110000_0);
        step(20);
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        chk("flush_level", 32'(level_o), 32'd0);
        chk("flush_frame_busy", 32'(idle_o), 32'd0);
        step(100);
        chk("flush_idle", 32'(idle_o), 32'd1);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sia_txq_fc.md
Name: sia_txq_fc

Overview:
Second-generation serial interface adapter (SIA) transmit queue. Holds pre-framed words (start, data and stop bits supplied by software, LSB first) in a parametrised FIFO. Shifts each word out at a programmable bit rate with an optional bit clock. Adds CTS hardware flow control, break generation, flush, FIFO fill level and a sticky overflow flag. Sits between the bus-side SIA register file and the pad.

Parameters:
SHIFT_REG_WIDTH, 12, width of a queued word and of the shift register
BAUD_RATE_WIDTH, 32, width of baud_i and the bit-period counter
DEPTH_BITS, 2, FIFO holds 2**DEPTH_BITS words
BITS_WIDTH, 5, width of bits_i

Ports:
clk_i  in  1  sole clock, rising edge
reset_i  in  1  asynchronous, active-low reset
dat_i  in  SHIFT_REG_WIDTH  framed word, bit 0 transmitted first
we_i  in  1  enqueue strobe
flush_i  in  1  discard all queued words; the frame in flight is unaffected
bits_i  in  BITS_WIDTH  bits per frame
baud_i  in  BAUD_RATE_WIDTH  bit period minus one, in clocks
txcmod_i  in  3  [2] clock enable, [1] invert, [0] static level when disabled
cts_en_i  in  1  enable flow control
cts_i  in  1  clear-to-send, asynchronous, active high
brk_i  in  1  request break (hold line low)
ovf_clr_i  in  1  clear ovf_o
txd_o  out  1  serial data
txc_o  out  1  bit clock
not_full_o  out  1  FIFO can accept a word
empty_o  out  1  FIFO empty
idle_o  out  1  FIFO empty, no frame in flight, no break
level_o  out  DEPTH_BITS+1  words queued, 0..2**DEPTH_BITS
ovf_o  out  1  sticky: a write was dropped

Behaviour:
- Reset (asynchronous, reset_i=0):
  - FIFO emptied; FSM goes to IDLE.
  - Outputs: txd_o=1, txc_o=txcmod_i[1] (level only; no clock during reset), not_full_o=1, empty_o=1, idle_o=1, level_o=0, ovf_o=0.
  - Reset mid-frame aborts the frame; the line returns to mark at once.
- FIFO:
  - A write occurs when we_i=1 and level<2**DEPTH_BITS.
  - A write while full is dropped and sets ovf_o. This holds even if a pop happens on the same edge.
  - A pop and a write on the same edge leave the level unchanged.
  - flush_i has priority over we_i on the same edge.
  - ovf_clr_i clears ovf_o; a new overflow on the same edge wins.
  - All status outputs are registered or derived directly from the registered count.
- cts_i passes through a two-flop synchroniser. start_ok = !cts_en_i | cts_sync.
- FSM states: IDLE, SHIFT, BREAK.
  - IDLE: txd_o=1.
    - If brk_i=1: go to BREAK.
    - Else if !empty and start_ok: pop the head, load the shift register, set bitcnt=min(bits_i, SHIFT_REG_WIDTH) and baudcnt=baud_i, go to SHIFT.
    - If bits_i=0: pop, discard, stay in IDLE.
  - SHIFT: txd_o = shreg[0].
    - baudcnt decrements each clock.
    - At 0: reload baud_i, shift right filling with 1, decrement bitcnt.
    - When bitcnt reaches 0 the frame ends and the IDLE decision is taken on that same edge. Back-to-back frames therefore have no gap: each bit lasts exactly baud_i+1 clocks.
    - cts or brk changes mid-frame never abort a frame.
  - BREAK: txd_o=0 while brk_i=1. On brk_i=0, return to IDLE.
- Sampling rules:
  - baud_i is sampled at every reload.
  - bits_i is sampled only at load.
- Latency: on an idle queue with start_ok=1, a write at edge N makes the first bit appear on txd_o after edge N+1.
- txc_o:
  - txcmod_i[2]=0: constant txcmod_i[0].
  - txcmod_i[2]=1 in SHIFT: (baudcnt <= baud_i>>1) ^ txcmod_i[1], i.e. low for the first half of the bit and rising mid-bit.
  - txcmod_i[2]=1 outside SHIFT: txcmod_i[1].
- idle_o = empty & state==IDLE. It falls on the edge the first word is written.

Decomposition:
- Shared include sia_pkg holds:
  - FSM state encodings.
  - txcmod bit indices.
  - Default widths.
- One sub-module, sia_fifo: synchronous FIFO with level, flush and dropped-write flag. It is reused by the receive queue.
- The shifter and FSM stay in sia_txq_fc.

Test Plan:
1. 8N1 frame: baud_i=49, bits_i=10, dat_i=12'b111_11101101_0 -> txd_o is 0 for 50 clocks, then 1,0,1,1,0,1,1,1 for 50 clocks each, then 1. idle_o rises 500 clocks after the start bit begins.
2. Fill/overflow: cts_en_i=1, cts_i=0, write 5 words -> level_o=4, not_full_o=0, ovf_o=1. Raising cts_i -> 4 frames back-to-back, stop bit directly followed by start bit, 2000 clocks total. Pulsing ovf_clr_i -> ovf_o=0.
3. CTS drop mid-frame -> the current frame completes. The next start bit waits until 2 clocks after cts_i rises.
4. Break: brk_i=1 while idle -> txd_o=0 from the next clock. Break raised mid-frame -> the frame finishes, then the line goes low. brk_i=0 -> txd_o=1 and queued data resumes.
5. Clock modes, baud_i=9:
   - txcmod_i=3'b100 -> txc_o low 5 clocks, then high 5, per bit.
   - 3'b110 -> inverted.
   - 3'b001 -> constant 1.
6. Boundaries:
   - bits_i=14 with width 12 -> 12 bits sent.
   - bits_i=0 -> word discarded, txd_o stays 1.
   - reset_i low mid-frame -> txd_o=1 immediately, level_o=0.
   - flush_i mid-frame -> the frame completes, then idle.
